sd_spi_port: RTL and testbench



---
 rtl/sd_spi_pkg.sv | 22 ++
 rtl/sd_spi_shifter.sv | 116 +++++++++++
 rtl/sd_spi_port.sv | 139 +++++++++++++
 tb/tb_sd_spi_port.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
// Shared constants and shifter state encoding for the SD-card SPI port.
package sd_spi_pkg;

  localparam logic REG_DATA = 1'b0;
  localparam logic REG_STAT = 1'b1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_CD   = 1;
  localparam int STAT_WP   = 2;
  localparam int STAT_OVR  = 3;
  localparam int STAT_SS   = 4;
  localparam int STAT_FAST = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOW,
    HIGH,
    DONE
  } shift_state_e;

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte shifter: MSB first, SCK half-period of div_i clocks,
// divider latched when a transfer starts.
module sd_spi_shifter
  import sd_spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       tx_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             busy_o,
  output logic [7:0]       rx_o,
  output logic             rx_valid_o,
  output logic             sck_o,
  output logic             mosi_o,
  input  logic             miso_i
);

  shift_state_e     state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             half_done;

  assign half_done  = (cnt_q == div_q - DIV_W'(1));
  assign busy_o     = (state_q != IDLE);
  assign rx_o       = shift_q;
  assign rx_valid_o = (state_q == DONE);
  assign sck_o      = sck_q;
  assign mosi_o     = mosi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
    end
  end

  // The shift register doubles as TX source (bit 7 out) and RX sink (bit 0 in).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    unique case (state_q)
      IDLE: begin
        sck_d  = 1'b0;
        mosi_d = 1'b1;
        if (start_i) begin
          shift_d = tx_i;
          div_d   = div_i;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        mosi_d  = shift_q[7];
        cnt_d   = '0;
        state_d = LOW;
      end
      LOW: begin
        if (half_done) begin
          sck_d   = 1'b1;
          shift_d = {shift_q[6:0], miso_i};
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      HIGH: begin
        if (half_done) begin
          sck_d = 1'b0;
          cnt_d = '0;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = DONE;
          end else begin
            mosi_d  = shift_q[7];
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        mosi_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/sd_spi_port.sv
// CPU-facing SD-card SPI port: strobe synchronizers, shadow latches, DATA and
// STATUS/CTRL registers. Optional macro SD_SPI_AUTOREAD_EN: DATA read starts a 0xFF transfer.
module sd_spi_port
  import sd_spi_pkg::*;
#(
  parameter int SLOW_DIV = 100,
  parameter int FAST_DIV = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CS,
  input  logic       RD_N,
  input  logic       WR_N,
  input  logic       A0,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       SD_SCK,
  output logic       SD_MOSI,
  output logic       SD_CS_N,
  input  logic       SD_MISO,
  input  logic       SD_CD_N,
  input  logic       SD_WP
);

  localparam int DIV_MAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX) + 1;
  localparam logic [DIV_W-1:0] SLOW_L = DIV_W'(SLOW_DIV);
  localparam logic [DIV_W-1:0] FAST_L = DIV_W'(FAST_DIV);

  logic [2:0] wr_sync_q, rd_sync_q;
  logic       wr_pend_q, rd_pend_q;
  logic       wa0_q, ra0_q;
  logic [7:0] wd_q;
  logic       ss_q, ss_d;
  logic       fast_q, fast_d;
  logic       ovr_q, ovr_d;
  logic [7:0] rxdata_q, rxdata_d;
  logic       wr_commit, rd_commit;
  logic       start;
  logic [7:0] tx;
  logic       busy, rx_valid;
  logic [7:0] rx;
  logic [7:0] status;

  // Commit fires on the synchronized rising edge, only for cycles that hit us.
  assign wr_commit = wr_sync_q[1] & ~wr_sync_q[2] & wr_pend_q;
  assign rd_commit = rd_sync_q[1] & ~rd_sync_q[2] & rd_pend_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_sync_q <= '1;
      rd_sync_q <= '1;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      ss_q      <= 1'b0;
      fast_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rxdata_q  <= 8'hFF;
    end else begin
      wr_sync_q <= {wr_sync_q[1:0], WR_N};
      rd_sync_q <= {rd_sync_q[1:0], RD_N};
      wr_pend_q <= (CS & ~WR_N) | (wr_pend_q & ~wr_commit);
      rd_pend_q <= (CS & ~RD_N) | (rd_pend_q & ~rd_commit);
      ss_q      <= ss_d;
      fast_q    <= fast_d;
      ovr_q     <= ovr_d;
      rxdata_q  <= rxdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (CS && !WR_N) begin
      wa0_q <= A0;
      wd_q  <= D_IN;
    end
    if (CS && !RD_N) begin
      ra0_q <= A0;
    end
  end

  always_comb begin
    ss_d     = ss_q;
    fast_d   = fast_q;
    ovr_d    = ovr_q;
    rxdata_d = rx_valid ? rx : rxdata_q;
    start    = 1'b0;
    tx       = wd_q;
    if (wr_commit && wa0_q == REG_STAT) begin
      ss_d   = wd_q[0];
      fast_d = wd_q[1];
    end
    if (rd_commit && ra0_q == REG_STAT) begin
      ovr_d = 1'b0;
    end
    // Overrun set comes last so it wins over a same-cycle STATUS-read clear.
    if (wr_commit && wa0_q == REG_DATA) begin
      if (busy) ovr_d = 1'b1;
      else      start = 1'b1;
    end
`ifdef SD_SPI_AUTOREAD_EN
    else if (rd_commit && ra0_q == REG_DATA && !busy) begin
      start = 1'b1;
      tx    = 8'hFF;
    end
`endif
  end

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_CD]   = ~SD_CD_N;
    status[STAT_WP]   = SD_WP;
    status[STAT_OVR]  = ovr_q;
    status[STAT_SS]   = ss_q;
    status[STAT_FAST] = fast_q;
  end

  assign D_OE    = CS & ~RD_N;
  assign D_OUT   = A0 ? status : rxdata_q;
  assign SD_CS_N = ~ss_q;

  sd_spi_shifter #(
    .DIV_W(DIV_W)
  ) u_shifter (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .start_i   (start),
    .tx_i      (tx),
    .div_i     (fast_q ? FAST_L : SLOW_L),
    .busy_o    (busy),
    .rx_o      (rx),
    .rx_valid_o(rx_valid),
    .sck_o     (SD_SCK),
    .mosi_o    (SD_MOSI),
    .miso_i    (SD_MISO)
  );

endmodule

// File: tb/tb_sd_spi_port.sv
// Directed bench for sd_spi_port: bus register access, SPI byte transfers,
// overrun handling and mid-transfer reset.
module tb_sd_spi_port;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CS = 1'b0;
  logic       RD_N = 1'b1;
  logic       WR_N = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] D_IN = 8'h00;
  logic [7:0] D_OUT;
  logic       D_OE;
  logic       SD_SCK, SD_MOSI, SD_CS_N;
  logic       SD_CD_N = 1'b0;
  logic       SD_WP = 1'b0;
  logic       loop_en = 1'b0;
  logic       miso_val = 1'b0;
  logic       SD_MISO;

  int checks = 0;
  int errors = 0;

  logic [7:0] cap = 8'h00;
  int         npulse = 0;
  time        last_rise = 0;
  time        prev_rise = 0;

  assign SD_MISO = loop_en ? SD_MOSI : miso_val;

  always #5 CLK = ~CLK;

  sd_spi_port #(
    .SLOW_DIV(100),
    .FAST_DIV(2)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .CS     (CS),
    .RD_N   (RD_N),
    .WR_N   (WR_N),
    .A0     (A0),
    .D_IN   (D_IN),
    .D_OUT  (D_OUT),
    .D_OE   (D_OE),
    .SD_SCK (SD_SCK),
    .SD_MOSI(SD_MOSI),
    .SD_CS_N(SD_CS_N),
    .SD_MISO(SD_MISO),
    .SD_CD_N(SD_CD_N),
    .SD_WP  (SD_WP)
  );

  always @(posedge SD_SCK) begin
    cap       = {cap[6:0], SD_MOSI};
    npulse    = npulse + 1;
    prev_rise = last_rise;
    last_rise = $time;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic a0, input logic [7:0] d, input bit settle);
    @(negedge CLK);
    CS = 1'b1; A0 = a0; D_IN = d; WR_N = 1'b0;
    repeat (3) @(negedge CLK);
    WR_N = 1'b1; CS = 1'b0;
    if (settle) repeat (5) @(negedge CLK);
  endtask

  task automatic bus_read(input logic a0, output logic [7:0] d, output logic oe);
    @(negedge CLK);
    CS = 1'b1; A0 = a0; RD_N = 1'b0;
    repeat (2) @(negedge CLK);
    d  = D_OUT;
    oe = D_OE;
    RD_N = 1'b1; CS = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  // Counts negedge samples with BUSY high until it falls; done=0 on timeout.
  task automatic wait_idle(output int nbusy, output logic done);
    logic seen;
    nbusy = 0; done = 1'b0; seen = 1'b0;
    A0 = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (D_OUT[0]) begin
        nbusy++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       oe;
    int         nb;
    int         base;
    logic       done;

    repeat (3) @(negedge CLK);
    check("rst_cs_n", SD_CS_N, 1'b1);
    check("rst_sck", SD_SCK, 1'b0);
    check("rst_mosi", SD_MOSI, 1'b1);
    check("rst_oe", D_OE, 1'b0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    bus_read(1'b0, d, oe);
    check("rst_rxdata", d, 8'hFF);
    check("rd_oe", oe, 1'b1);
    bus_read(1'b1, d, oe);
    check("rst_status", d, 8'h02);

    // Fast loopback transfer of 0xA5
    bus_write(1'b1, 8'h03, 1'b1);
    check("ss_cs_n", SD_CS_N, 1'b0);
    loop_en = 1'b1;
    base = npulse;
    bus_write(1'b0, 8'hA5, 1'b0);
    wait_idle(nb, done);
    check("a5_done", done, 1'b1);
    check("a5_busy_cycles", nb, 34);
    check("a5_pulses", npulse - base, 8);
    check("a5_mosi", cap, 8'hA5);
    bus_read(1'b0, d, oe);
    check("a5_rx", d, 8'hA5);
    bus_read(1'b1, d, oe);
    check("a5_status", d, 8'h32);
    loop_en = 1'b0;

    // Slow transfer of 0x40, MISO low
    miso_val = 1'b0;
    bus_write(1'b1, 8'h01, 1'b1);
    base = npulse;
    bus_write(1'b0, 8'h40, 1'b0);
    wait_idle(nb, done);
    check("slow_done", done, 1'b1);
    check("slow_busy_cycles", nb, 1602);
    check("slow_pulses", npulse - base, 8);
    check("slow_period", 32'((last_rise - prev_rise) / 10), 200);
    check("slow_mosi", cap, 8'h40);
    bus_read(1'b0, d, oe);
    check("slow_rx", d, 8'h00);

    // Overrun: second DATA write while busy is dropped
    SD_CD_N = 1'b1;
    bus_write(1'b1, 8'h00, 1'b1);
    base = npulse;
    bus_write(1'b0, 8'h11, 1'b1);
    bus_write(1'b0, 8'h22, 1'b1);
    bus_read(1'b1, d, oe);
    check("ovr_status1", d, 8'h09);
    bus_read(1'b1, d, oe);
    check("ovr_status2", d, 8'h01);
    wait_idle(nb, done);
    check("ovr_done", done, 1'b1);
    check("ovr_pulses", npulse - base, 8);
    check("ovr_mosi", cap, 8'h11);

    // Reset asserted in the middle of a fast transfer
    SD_CD_N = 1'b0;
    bus_write(1'b1, 8'h03, 1'b1);
    base = npulse;
    bus_write(1'b0, 8'h3C, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (npulse - base >= 4) begin
        done = 1'b1;
        break;
      end
    end
    check("mid_reached_bit4", done, 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_sck", SD_SCK, 1'b0);
    check("mid_rst_mosi", SD_MOSI, 1'b1);
    check("mid_rst_cs_n", SD_CS_N, 1'b1);
    SD_CD_N = 1'b1;
    SD_WP   = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    bus_read(1'b1, d, oe);
    check("mid_status", d, 8'h00);
    bus_read(1'b0, d, oe);
    check("mid_rxdata", d, 8'hFF);

`ifdef SD_SPI_AUTOREAD_EN
    miso_val = 1'b1;
    bus_write(1'b1, 8'h03, 1'b1);
    base = npulse;
    @(negedge CLK);
    CS = 1'b1; A0 = 1'b0; RD_N = 1'b0;
    repeat (2) @(negedge CLK);
    RD_N = 1'b1; CS = 1'b0;
    wait_idle(nb, done);
    check("auto_done", done, 1'b1);
    check("auto_pulses", npulse - base, 8);
    check("auto_mosi", cap, 8'hFF);
    bus_read(1'b0, d, oe);
    check("auto_rx", d, 8'hFF);
    wait_idle(nb, done);
    check("auto_done2", done, 1'b1);
`else
    base = npulse;
    bus_read(1'b0, d, oe);
    check("noauto_rx", d, 8'hFF);
    A0 = 1'b1;
    repeat (20) @(negedge CLK);
    check("noauto_busy", D_OUT[0], 1'b0);
    check("noauto_pulses", npulse - base, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
